// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory arbiter with per-transaction response timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q;
  logic             last_grant_q;  // 1 = data, 0 = fetch
  logic [CNT_W-1:0] cnt_q;
  logic             grant_d_c;
  logic             timeout_c;
  logic [31:0]      resp_rdata_c;

  // Contention resolution between the two requesters
  always_comb begin
    grant_d_c = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_d_c = d_valid && (!i_valid || !last_grant_q);
`else
    grant_d_c = d_valid;
`endif
  end

  assign timeout_c    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIM);
  assign resp_rdata_c = mem_ready ? mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_valid    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'h0;
      i_ready      <= 1'b0;
      i_rdata      <= 32'h0;
      i_err        <= 1'b0;
      d_ready      <= 1'b0;
      d_rdata      <= 32'h0;
      d_err        <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid || d_valid) begin
            state_q      <= BUSY;
            mem_valid    <= 1'b1;
            mem_instr    <= !grant_d_c;
            last_grant_q <= grant_d_c;
            cnt_q        <= '0;
            if (grant_d_c) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              mem_addr  <= i_addr;
              mem_wdata <= 32'h0;
              mem_wstrb <= 4'h0;
            end
          end
        end
        BUSY: begin
          // mem_ready takes precedence over a coincident timeout
          if (mem_ready || timeout_c) begin
            state_q   <= RESP;
            mem_valid <= 1'b0;
            if (last_grant_q) begin
              d_ready <= 1'b1;
              d_rdata <= resp_rdata_c;
              d_err   <= !mem_ready;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= resp_rdata_c;
              i_err   <= !mem_ready;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
